uart_rx_deser: RTL and testbench
================================

Name: uart_rx_deser

Overview:
- UART receive deserializer with 16x oversampling. Sits directly upstream of the RX FIFO.
- Synchronizes the serial line, detects and validates the start bit, and samples 5–8 data bits LSB-first, an optional parity bit and one stop bit.
- Emits one push pulse per received character, carrying the byte and its per-character error flags, toward the FIFO (push_in/din).

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchronizer stages on rx (minimum 2).
- OSR, 16, baud_pulse ticks per bit; mid-bit sample point is OSR/2.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-low
- en  input  1  receiver enable; low forces IDLE and suppresses push
- baud_pulse  input  1  one-clk strobe at 16x baud rate
- rx  input  1  asynchronous serial line, idle high
- wls  input  2  word length: 00=5, 01=6, 10=7, 11=8 bits
- pen  input  1  parity enable
- eps  input  1  even parity select (1=even, 0=odd)
- stick  input  1  stick parity; expected parity bit = ~eps
- push  output  1  one-clk pulse: character complete (to FIFO push_in)
- dout  output  8  received byte; unused MSBs are 0
- pe  output  1  parity error for the character in dout
- fe  output  1  framing error (stop bit sampled 0)
- bi  output  1  break: data, parity (if enabled) and stop all 0
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; push=0; dout=8'h00; pe=fe=bi=0; busy=0.
  - Synchronizer and previous-sample registers load 1.
  - Tick and bit counters clear.
  - Reset mid-character discards the partial character; no push is generated.
- Synchronization: rx_s = rx delayed by SYNC_STAGES clk. All decisions use rx_s.
- State machine (all state and counter updates happen only on clk edges where baud_pulse=1, except push and the en override):
  - IDLE: start is detected when rx_s=0 and the previous baud-sampled rx_s=1 (falling edge). Go to START with tick=0.
    - A line held low (e.g. after a break) never retriggers; the line must return high first.
  - START: count ticks. At tick OSR/2-1, re-sample rx_s:
    - 1 → false start, return to IDLE, no push.
    - 0 → go to DATA with tick=0, bit=0.
  - DATA: sample rx_s at every tick=OSR-1 (bit centre) into shift bit position `bit`. After bit = N-1 (N = wls+5):
    - go to PARITY if pen=1;
    - otherwise go to STOP.
  - PARITY: sample rx_s at the next bit centre and go to STOP.
  - STOP: sample rx_s at the next bit centre, then go to IDLE. On the following clk:
    - push=1 for exactly one cycle;
    - dout, pe, fe and bi update in the same cycle as push and hold until the next push.
- Parity check:
  - pen=0 → pe=0.
  - stick=1 → pe = (parity_bit != ~eps).
  - Otherwise pe = (^data ^ parity_bit) != ~eps, i.e. even requires total XOR 0 and odd requires total XOR 1.
- fe = (stop sample == 0).
- bi = fe & (data == 0) & (pen ? parity_bit == 0 : 1).
- wls, pen, eps and stick are captured at start-bit validation. Changes mid-character do not affect that character.
- en=0: synchronously forces IDLE; push=0. dout and the error flags hold their values. Setting en=1 waits for a fresh falling edge.
- baud_pulse coincident with en falling: en has priority.
- Latency: push rises 1 clk after the baud_pulse edge that samples the stop bit. The next start bit is accepted on the baud_pulse immediately after STOP, so back-to-back characters with a single stop bit are supported.
- No push occurs for a false start, for en=0 or for reset. Flow control is not used: downstream FIFO full/overrun is the FIFO's responsibility.

Test Plan:
- 8N1, send 0xA5 with a clean 16x baud_pulse → exactly one push; dout=0xA5; pe=fe=bi=0; push occurs 1 clk after the stop-bit centre sample.
- wls=00 (5 bits), pen=1, eps=1, send 0x13 with correct parity 1 → dout=0x13, pe=0. Repeat with parity bit 0 → pe=1, dout=0x13.
- 8N1 glitch: rx low for 5 ticks then high → no push, busy returns to 0 by tick 8.
- Break: hold rx low for 2 character times with pen=1 → one push, dout=0x00, fe=1, bi=1. No further push until rx goes high, then a valid 0x55 frame → dout=0x55, bi=fe=0.
- Back-to-back: frames 0x01, 0xFF, 0x80 (8N1) with no idle gap → three pushes in order with correct dout; stop-bit fe=0 each.
- Mid-frame disruption: rst=0 asserted during DATA bit 3 → outputs return to reset values immediately, with no push. Repeating with en dropped during DATA gives the same result, except dout and the error flags hold their values. In both cases the next full frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: oversampled start/data/parity/stop capture that
// emits one push per character, with its error flags, toward the RX FIFO.
module uart_rx_deser #(
  parameter int SYNC_STAGES = 2,
  parameter int OSR         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       baud_pulse,
  input  logic       rx,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       stick,
  output logic       push,
  output logic [7:0] dout,
  output logic       pe,
  output logic       fe,
  output logic       bi,
  output logic       busy
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int TW     = (OSR > 2) ? $clog2(OSR) : 1;
  localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] TICK_END  = TW'(OSR - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic parity_err(
    input logic [7:0] data,
    input logic       par_bit,
    input logic       par_en,
    input logic       even,
    input logic       stk
  );
    logic want_s;
    want_s = ~even;
    if (!par_en) begin
      parity_err = 1'b0;
    end else if (stk) begin
      parity_err = (par_bit != want_s);
    end else begin
      parity_err = ((^data) ^ par_bit) != want_s;
    end
  endfunction

  logic [SYNC_N-1:0] sync_r;
  logic              rx_s;
  logic              prev_r;
  state_t            state_r, state_n;
  logic [TW-1:0]     tick_r, tick_n;
  logic [2:0]        bit_r, bit_n;
  logic [7:0]        shift_r, shift_n;
  logic              par_r, par_n;
  logic [2:0]        nbits_m1_r;
  logic              pen_r, eps_r, stick_r;
  logic              cfg_load_s, stop_hit_s;
  logic              done_r, stop_r;
  logic              push_r, pe_r, fe_r, bi_r, busy_r;
  logic [7:0]        dout_r;

  assign rx_s = sync_r[SYNC_N-1];

  // Metastability synchronizer on the asynchronous serial line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= {SYNC_N{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_N-2:0], rx};
    end
  end

  // Frame sequencing; all motion is gated by baud_pulse and en overrides it
  always_comb begin
    state_n    = state_r;
    tick_n     = tick_r;
    bit_n      = bit_r;
    shift_n    = shift_r;
    par_n      = par_r;
    cfg_load_s = 1'b0;
    stop_hit_s = 1'b0;
    if (!en) begin
      state_n = ST_IDLE;
      tick_n  = TICK_ZERO;
      bit_n   = 3'd0;
    end else if (baud_pulse) begin
      case (state_r)
        ST_IDLE: begin
          if (!rx_s && prev_r) begin
            state_n = ST_START;
            tick_n  = TICK_ZERO;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_START: begin
          if (tick_r == TICK_MID) begin
            tick_n = TICK_ZERO;
            if (rx_s) begin
              state_n = ST_IDLE;
            end else begin
              state_n    = ST_DATA;
              bit_n      = 3'd0;
              shift_n    = 8'h00;
              par_n      = 1'b0;
              cfg_load_s = 1'b1;
            end
          end else begin
            tick_n = tick_r + TICK_ONE;
          end
        end
        ST_DATA: begin
          if (tick_r == TICK_END) begin
            tick_n         = TICK_ZERO;
            shift_n[bit_r] = rx_s;
            if (bit_r == nbits_m1_r) begin
              state_n = pen_r ? ST_PARITY : ST_STOP;
            end else begin
              bit_n = bit_r + 3'd1;
            end
          end else begin
            tick_n = tick_r + TICK_ONE;
          end
        end
        ST_PARITY: begin
          if (tick_r == TICK_END) begin
            tick_n  = TICK_ZERO;
            par_n   = rx_s;
            state_n = ST_STOP;
          end else begin
            tick_n = tick_r + TICK_ONE;
          end
        end
        ST_STOP: begin
          if (tick_r == TICK_END) begin
            tick_n     = TICK_ZERO;
            state_n    = ST_IDLE;
            stop_hit_s = 1'b1;
          end else begin
            tick_n = tick_r + TICK_ONE;
          end
        end
        default: begin
          state_n = ST_IDLE;
          tick_n  = TICK_ZERO;
          bit_n   = 3'd0;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // State, counters, character config and the stop-bit handoff register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      tick_r     <= TICK_ZERO;
      bit_r      <= 3'd0;
      shift_r    <= 8'h00;
      par_r      <= 1'b0;
      prev_r     <= 1'b1;
      nbits_m1_r <= 3'd7;
      pen_r      <= 1'b0;
      eps_r      <= 1'b0;
      stick_r    <= 1'b0;
      done_r     <= 1'b0;
      stop_r     <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r <= state_n;
      tick_r  <= tick_n;
      bit_r   <= bit_n;
      shift_r <= shift_n;
      par_r   <= par_n;
      busy_r  <= (state_n != ST_IDLE);
      done_r  <= stop_hit_s;
      if (baud_pulse) begin
        prev_r <= rx_s;
      end
      // Config is frozen at start validation so mid-character changes are ignored
      if (cfg_load_s) begin
        nbits_m1_r <= 3'd4 + {1'b0, wls};
        pen_r      <= pen;
        eps_r      <= eps;
        stick_r    <= stick;
      end
      if (stop_hit_s) begin
        stop_r <= rx_s;
      end
    end
  end

  // Character delivery: one-cycle push with byte and flags held until the next
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_r <= 1'b0;
      dout_r <= 8'h00;
      pe_r   <= 1'b0;
      fe_r   <= 1'b0;
      bi_r   <= 1'b0;
    end else if (en && done_r) begin
      push_r <= 1'b1;
      dout_r <= shift_r;
      pe_r   <= parity_err(shift_r, par_r, pen_r, eps_r, stick_r);
      fe_r   <= ~stop_r;
      bi_r   <= ~stop_r & (shift_r == 8'h00) & (~pen_r | ~par_r);
    end else begin
      push_r <= 1'b0;
    end
  end

  assign push = push_r;
  assign dout = dout_r;
  assign pe   = pe_r;
  assign fe   = fe_r;
  assign bi   = bi_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: line waveforms built per baud tick, decoded by an
// array-level model of the framing rules, and compared against recorded pushes.
module tb_uart_rx_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       baud_pulse = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] wls = 2'b11;
  logic       pen = 1'b0;
  logic       eps = 1'b0;
  logic       stick = 1'b0;
  logic       push;
  logic [7:0] dout;
  logic       pe, fe, bi, busy;

  int errors = 0;
  int checks = 0;

  bit         wave[$];
  int         cur_tick = 0;
  int         cur_ph = 0;
  int         rec_time[$];
  logic [7:0] rec_dout[$];
  logic [2:0] rec_flags[$];
  int         exp_time[$];
  logic [7:0] exp_dout[$];
  logic [2:0] exp_flags[$];
  logic [7:0] last_dout = 8'h00;
  logic [2:0] last_flags = 3'b000;

  uart_rx_deser #(.SYNC_STAGES(2), .OSR(16)) dut (
    .clk(clk), .rst(rst), .en(en), .baud_pulse(baud_pulse), .rx(rx),
    .wls(wls), .pen(pen), .eps(eps), .stick(stick),
    .push(push), .dout(dout), .pe(pe), .fe(fe), .bi(bi), .busy(busy)
  );

  always #5 clk = ~clk;

  // record every push with the tick/phase of the clock edge that produced it
  always @(posedge clk) begin
    #1;
    if (push === 1'b1) begin
      rec_time.push_back(cur_tick * 4 + cur_ph);
      rec_dout.push_back(dout);
      rec_flags.push_back({pe, fe, bi});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic add_level(input bit v, input int ticks);
    for (int i = 0; i < ticks; i++) wave.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] d, input int n, input bit p_en, input bit par, input bit stopb);
    add_level(1'b0, 16);
    for (int k = 0; k < n; k++) add_level(d[k], 16);
    if (p_en) add_level(par, 16);
    add_level(stopb, 16);
  endtask

  function automatic bit good_par(input logic [7:0] d, input int n, input bit even, input bit stk);
    int ones = 0;
    for (int k = 0; k < n; k++) if (d[k]) ones++;
    if (stk) return !even;
    if (even) return (ones % 2) == 1;
    return (ones % 2) == 0;
  endfunction

  // reference: walk the per-tick line and apply the framing rules directly
  task automatic decode(input int n, input bit p_en, input bit even, input bit stk);
    int t, s, ones;
    logic [7:0] d;
    bit par, stopb, pe_m, fe_m, bi_m;
    exp_time.delete(); exp_dout.delete(); exp_flags.delete();
    t = 1;
    while (t < wave.size()) begin
      if (wave[t] == 1'b0 && wave[t-1] == 1'b1) begin
        if (t + 8 >= wave.size()) break;
        if (wave[t+8] == 1'b1) begin
          t = t + 9;
          continue;
        end
        d = 8'h00;
        ones = 0;
        for (int k = 0; k < n; k++) begin
          d[k] = wave[t + 24 + 16 * k];
          if (wave[t + 24 + 16 * k]) ones++;
        end
        par = p_en ? wave[t + 24 + 16 * n] : 1'b0;
        s = t + 24 + 16 * (n + (p_en ? 1 : 0));
        if (s + 1 >= wave.size()) break;
        stopb = wave[s];
        if (!p_en) pe_m = 1'b0;
        else if (stk) pe_m = (par == even);
        else if (even) pe_m = ((ones + int'(par)) % 2) == 1;
        else pe_m = ((ones + int'(par)) % 2) == 0;
        fe_m = !stopb;
        bi_m = fe_m && (d == 8'h00) && !(p_en && par);
        exp_time.push_back((s + 1) * 4);
        exp_dout.push_back(d);
        exp_flags.push_back({pe_m, fe_m, bi_m});
        t = s + 1;
      end else begin
        t++;
      end
    end
  endtask

  task automatic play(input int abort_at, input int abort_ph, input int kind);
    rec_time.delete(); rec_dout.delete(); rec_flags.delete();
    for (int t = 0; t < wave.size(); t++) begin
      for (int ph = 0; ph < 4; ph++) begin
        @(negedge clk);
        cur_tick = t;
        cur_ph = ph;
        rx = wave[t];
        baud_pulse = (ph == 3);
        if (t == abort_at && ph == abort_ph) begin
          chk("busy_before_abort", busy, 1);
          if (kind == 0) begin
            rst = 1'b0;
            #1;
            chk("rst_push", push, 0);
            chk("rst_dout", dout, 0);
            chk("rst_flags", {pe, fe, bi}, 0);
            chk("rst_busy", busy, 0);
            last_dout = 8'h00;
            last_flags = 3'b000;
          end else begin
            en = 1'b0;
            @(posedge clk);
            #1;
            chk("en_busy", busy, 0);
            chk("en_push", push, 0);
            chk("en_dout_hold", dout, last_dout);
            chk("en_flags_hold", {pe, fe, bi}, last_flags);
          end
          baud_pulse = 1'b0;
          rx = 1'b1;
          repeat (4) @(negedge clk);
          rst = 1'b1;
          en = 1'b1;
          repeat (4) @(negedge clk);
          return;
        end
      end
    end
    @(negedge clk);
    baud_pulse = 1'b0;
    cur_tick = wave.size();
    cur_ph = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_and_check(input string tag, input int n, input bit p_en, input bit even, input bit stk);
    int m;
    wls = 2'(n - 5);
    pen = p_en;
    eps = even;
    stick = stk;
    decode(n, p_en, even, stk);
    play(-1, 0, 0);
    chk({tag, "_count"}, rec_time.size(), exp_time.size());
    m = (rec_time.size() < exp_time.size()) ? rec_time.size() : exp_time.size();
    for (int i = 0; i < m; i++) begin
      chk({tag, "_time"}, rec_time[i], exp_time[i]);
      chk({tag, "_dout"}, rec_dout[i], exp_dout[i]);
      chk({tag, "_flags"}, rec_flags[i], exp_flags[i]);
    end
    if (exp_time.size() > 0) begin
      last_dout = exp_dout[exp_time.size() - 1];
      last_flags = exp_flags[exp_time.size() - 1];
    end
    wave.delete();
  endtask

  initial begin
    int n, nfr;
    bit p_en, ev, stk, par, stopb;
    logic [7:0] d;

    #3 rst = 1'b0;
    #1;
    chk("reset_push", push, 0);
    chk("reset_dout", dout, 0);
    chk("reset_flags", {pe, fe, bi}, 0);
    chk("reset_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    repeat (2) @(negedge clk);

    add_level(1'b1, 20); add_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1); add_level(1'b1, 30);
    run_and_check("a5_8n1", 8, 1'b0, 1'b0, 1'b0);
    chk("a5_dout_const", rec_dout[0], 8'hA5);
    chk("a5_time_const", rec_time[0], (20 + 24 + 16 * 8 + 1) * 4);

    add_level(1'b1, 20); add_frame(8'h13, 5, 1'b1, 1'b1, 1'b1);
    add_level(1'b1, 20); add_frame(8'h13, 5, 1'b1, 1'b0, 1'b1); add_level(1'b1, 30);
    run_and_check("w5_par", 5, 1'b1, 1'b1, 1'b0);
    chk("w5_good_pe", {rec_dout[0], rec_flags[0]}, {8'h13, 3'b000});
    chk("w5_bad_pe", {rec_dout[1], rec_flags[1]}, {8'h13, 3'b100});

    add_level(1'b1, 20); add_level(1'b0, 5); add_level(1'b1, 40);
    run_and_check("glitch", 8, 1'b0, 1'b0, 1'b0);
    chk("glitch_busy", busy, 0);

    add_level(1'b1, 20); add_level(1'b0, 352); add_level(1'b1, 40);
    add_frame(8'h55, 8, 1'b1, good_par(8'h55, 8, 1'b1, 1'b0), 1'b1); add_level(1'b1, 30);
    run_and_check("break", 8, 1'b1, 1'b1, 1'b0);
    chk("break_first", {rec_dout[0], rec_flags[0]}, {8'h00, 3'b011});
    chk("break_then55", {rec_dout[1], rec_flags[1]}, {8'h55, 3'b000});

    add_level(1'b1, 20);
    add_frame(8'h01, 8, 1'b0, 1'b0, 1'b1);
    add_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1);
    add_frame(8'h80, 8, 1'b0, 1'b0, 1'b1);
    add_level(1'b1, 30);
    run_and_check("b2b", 8, 1'b0, 1'b0, 1'b0);
    chk("b2b_seq", {rec_dout[0], rec_dout[1], rec_dout[2]}, {8'h01, 8'hFF, 8'h80});

    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(5, 8);
      p_en = ($urandom_range(0, 1) == 1);
      ev = ($urandom_range(0, 1) == 1);
      stk = ($urandom_range(0, 3) == 0);
      nfr = $urandom_range(1, 3);
      add_level(1'b1, $urandom_range(2, 20));
      for (int f = 0; f < nfr; f++) begin
        d = 8'($urandom) & (8'hFF >> (8 - n));
        par = good_par(d, n, ev, stk) ^ ($urandom_range(0, 3) == 0);
        stopb = ($urandom_range(0, 4) != 0);
        add_frame(d, n, p_en, par, stopb);
        add_level(1'b1, $urandom_range(2, 30));
      end
      add_level(1'b1, 20);
      run_and_check("random", n, p_en, ev, stk);
    end

    wls = 2'b11; pen = 1'b0; eps = 1'b0; stick = 1'b0;
    add_level(1'b1, 20); add_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1); add_level(1'b1, 40);
    play(20 + 16 + 3 * 16 + 8, 1, 0);
    chk("rst_abort_nopush", rec_time.size(), 0);
    wave.delete();
    add_level(1'b1, 20); add_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1); add_level(1'b1, 30);
    run_and_check("after_rst", 8, 1'b0, 1'b0, 1'b0);
    chk("after_rst_const", rec_dout[0], 8'h3C);

    add_level(1'b1, 20); add_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1); add_level(1'b1, 40);
    play(20 + 16 + 3 * 16 + 8, 3, 1);
    chk("en_abort_nopush", rec_time.size(), 0);
    wave.delete();
    add_level(1'b1, 20); add_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1); add_level(1'b1, 30);
    run_and_check("after_en", 8, 1'b0, 1'b0, 1'b0);
    chk("after_en_const", rec_dout[0], 8'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
